// File: rtl/instruction_loader_if.sv
// instruction_loader_if: byte-stream input and instruction-memory write bus of the boot loader.
//   in_byte/in_valid/in_ready : valid/ready byte stream (source -> loader)
//   imem_we/imem_addr/imem_wdata : word write port (loader -> instruction memory)
//   modport slave is the loader's view, modport master the stream source / memory side.
interface instruction_loader_if #(parameter int ADDR_W = 8);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (output in_byte, in_valid, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave (input in_byte, in_valid, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: boot loader that writes a checksummed little-endian word image into imem and holds the core in reset until done.
//   clk, reset   : clock and synchronous active-high reset
//   start        : one-cycle load request, honoured only when idle, done or errored
//   bus          : byte stream in, instruction-memory write port out
//   cpu_reset    : core reset, released only once a verified image is loaded
//   busy/done/error : load in progress / image verified / load aborted
//   words_loaded : words written during the current load
module instruction_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    instruction_loader_if.slave  bus,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          words_loaded
);
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERROR} state_t;
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);
    state_t      state, state_next;
    logic [15:0] count;
    logic [15:0] n_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  sum;
    logic [7:0]  sum_next;
    logic [23:0] word_buf;
    logic        fire;
    logic        last_word;
    assign bus.in_ready = state inside {CNT_LO, CNT_HI, DATA, CSUM};
    assign fire         = bus.in_valid & bus.in_ready;
    assign n_cnt        = {bus.in_byte, count[7:0]};
    assign sum_next     = sum + bus.in_byte;
    assign last_word    = byte_idx == 2'd3 && words_loaded + 16'd1 == count;
    assign busy         = bus.in_ready;
    assign done         = state == DONE;
    assign error        = state == ERROR;
    assign cpu_reset    = state != DONE;
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_next = CNT_LO;
            CNT_LO: if (fire) state_next = CNT_HI;
            CNT_HI: if (fire) state_next = {1'b0, n_cnt} > MAX_N ? ERROR : n_cnt == 16'd0 ? CSUM : DATA;
            DATA:   if (fire && last_word) state_next = CSUM;
            CSUM:   if (fire) state_next = sum_next == 8'd0 ? DONE : ERROR;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            byte_idx       <= '0;
            sum            <= '0;
            word_buf       <= '0;
            words_loaded   <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            state       <= state_next;
            bus.imem_we <= 1'b0;
            if (start && state inside {IDLE, DONE, ERROR}) begin
                words_loaded <= '0;
                byte_idx     <= '0;
                sum          <= '0;
            end
            if (fire) begin
                sum <= sum_next;
                if (state == CNT_LO) count[7:0] <= bus.in_byte;
                if (state == CNT_HI) count[15:8] <= bus.in_byte;
                if (state == DATA) begin
                    // bytes shift in from the top so the first three land little-endian in word_buf
                    byte_idx <= byte_idx + 2'd1;
                    word_buf <= {bus.in_byte, word_buf[23:8]};
                    if (byte_idx == 2'd3) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= ADDR_W'(words_loaded);
                        bus.imem_wdata <= {bus.in_byte, word_buf};
                        words_loaded   <= words_loaded + 16'd1;
                    end
                end
            end
        end
    end
endmodule
